// File: rtl/iob_native_initiator.sv
// iob_native_initiator
// Turns single commands from a valid/ready command port into IOb native-bus
// accesses, waits for the responder's ready pulse (or a cycle timeout), and
// returns read data / error on a valid/ready response port.
module iob_native_initiator #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                rst,
  // command port
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  // response port
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy,
  // native bus
  output logic                valid,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                ready
);

  localparam int STRB_W = DATA_W / 8;

  // A zero TIMEOUT disables the abort path entirely.
  localparam bit                   TIMEOUT_EN = (TIMEOUT != 0);
  // Counter value seen on the last cycle valid may be held.
  localparam logic [TIMEOUT_W-1:0] CNT_LAST   = TIMEOUT_W'(TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] CNT_ONE    = TIMEOUT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t               state_r,     state_nxt_s;
  logic [TIMEOUT_W-1:0] count_r,     count_nxt_s;
  logic                 valid_nxt_s;
  logic [ADDR_W-1:0]    address_nxt_s;
  logic [DATA_W-1:0]    wdata_nxt_s;
  logic [STRB_W-1:0]    wstrb_nxt_s;
  logic                 rsp_valid_nxt_s;
  logic [DATA_W-1:0]    rsp_rdata_nxt_s;
  logic                 rsp_err_nxt_s;

  // Handshake flags are pure decodes of the state.
  assign cmd_ready = (state_r == IDLE);
  assign busy      = (state_r != IDLE);

  // Next-state and next-output decode; every register holds unless a transition updates it.
  always_comb begin
    state_nxt_s     = state_r;
    count_nxt_s     = count_r;
    valid_nxt_s     = valid;
    address_nxt_s   = address;
    wdata_nxt_s     = wdata;
    wstrb_nxt_s     = wstrb;
    rsp_valid_nxt_s = rsp_valid;
    rsp_rdata_nxt_s = rsp_rdata;
    rsp_err_nxt_s   = rsp_err;

    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          address_nxt_s = cmd_addr;
          wdata_nxt_s   = cmd_wdata;
          wstrb_nxt_s   = cmd_wstrb;
          count_nxt_s   = {TIMEOUT_W{1'b0}};
          valid_nxt_s   = 1'b1;
          state_nxt_s   = REQ;
        end else begin
          state_nxt_s   = IDLE;
        end
      end
      REQ: begin
        // ready is checked first so a same-cycle answer beats the timeout
        if (ready) begin
          rsp_rdata_nxt_s = (wstrb == {STRB_W{1'b0}}) ? rdata : {DATA_W{1'b0}};
          rsp_err_nxt_s   = 1'b0;
          valid_nxt_s     = 1'b0;
          rsp_valid_nxt_s = 1'b1;
          state_nxt_s     = RSP;
        end else if (TIMEOUT_EN && (count_r == CNT_LAST)) begin
          rsp_rdata_nxt_s = {DATA_W{1'b0}};
          rsp_err_nxt_s   = 1'b1;
          valid_nxt_s     = 1'b0;
          rsp_valid_nxt_s = 1'b1;
          state_nxt_s     = RSP;
        end else begin
          count_nxt_s     = count_r + CNT_ONE;
        end
      end
      RSP: begin
        // stray ready here is ignored; only the response handshake moves on
        if (rsp_ready) begin
          rsp_valid_nxt_s = 1'b0;
          state_nxt_s     = IDLE;
        end else begin
          state_nxt_s     = RSP;
        end
      end
      default: begin
        valid_nxt_s     = 1'b0;
        rsp_valid_nxt_s = 1'b0;
        state_nxt_s     = IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      count_r   <= {TIMEOUT_W{1'b0}};
      valid     <= 1'b0;
      address   <= {ADDR_W{1'b0}};
      wdata     <= {DATA_W{1'b0}};
      wstrb     <= {STRB_W{1'b0}};
      rsp_valid <= 1'b0;
      rsp_rdata <= {DATA_W{1'b0}};
      rsp_err   <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      count_r   <= count_nxt_s;
      valid     <= valid_nxt_s;
      address   <= address_nxt_s;
      wdata     <= wdata_nxt_s;
      wstrb     <= wstrb_nxt_s;
      rsp_valid <= rsp_valid_nxt_s;
      rsp_rdata <= rsp_rdata_nxt_s;
      rsp_err   <= rsp_err_nxt_s;
    end
  end

endmodule
